// File: rtl/reset_sequencer.sv
// reset_sequencer: releases RAM reset, then CPU reset on a prescaler tick (or timeout), with soft re-sequence.
// Define RST_SEQ_WDT_EN to add a RUN-state watchdog that forces a re-sequence when not kicked.
module reset_sequencer #(
   parameter int HOLD_CYCLES  = 16,
   parameter int RAM_LEAD     = 8,
   parameter int TICK_TIMEOUT = 65535,
   parameter int WDT_CYCLES   = 16777216
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_tick,
   input  logic soft_rst_req,
   input  logic wdt_kick,
   output logic rst_ram_n,
   output logic rst_cpu_n,
   output logic ready,
   output logic tick_timeout,
   output logic wdt_fired
);
   typedef enum logic [1:0] {ASSERT, RAM_REL, WAIT_TICK, RUN} state_t;
   localparam int MAX_A = HOLD_CYCLES > RAM_LEAD ? HOLD_CYCLES : RAM_LEAD;
   localparam int MAX_B = MAX_A > TICK_TIMEOUT ? MAX_A : TICK_TIMEOUT;
`ifdef RST_SEQ_WDT_EN
   localparam int MAX_P = MAX_B > WDT_CYCLES ? MAX_B : WDT_CYCLES;
`else
   localparam int MAX_P = MAX_B;
`endif
   localparam int CW = $clog2(MAX_P) + 1;
   localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] LEAD_END = CW'(RAM_LEAD - 1);
   localparam logic [CW-1:0] TICK_END = CW'(TICK_TIMEOUT - 1);
   logic [1:0]    sync_q;
   logic          rst_int_n;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_sat, run_cnt;
   logic          ram_q, ram_d, cpu_q, cpu_d, rdy_q, rdy_d, tto_q, tto_d;
   logic          wdt_exp, trig;
   // Assertion is asynchronous; release is clocked through two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], 1'b1};
   end
   assign rst_int_n = sync_q[1];
   assign cnt_sat   = &cnt_q ? cnt_q : cnt_q + CW'(1);
`ifdef RST_SEQ_WDT_EN
   localparam logic [CW-1:0] WDT_END = CW'(WDT_CYCLES - 1);
   logic wdf_q;
   assign wdt_exp = state_q == RUN && cnt_q == WDT_END && !wdt_kick;
   assign run_cnt = wdt_kick ? '0 : cnt_sat;
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)                    wdf_q <= 1'b0;
      else if (wdt_exp || soft_rst_req) wdf_q <= wdt_exp;
   end
   assign wdt_fired = wdf_q;
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
   assign wdt_exp    = 1'b0;
   assign run_cnt    = '0;
   assign wdt_fired  = 1'b0;
`endif
   assign trig = soft_rst_req | wdt_exp;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_sat;
      ram_d   = ram_q;
      cpu_d   = cpu_q;
      rdy_d   = rdy_q;
      tto_d   = tto_q;
      case (state_q)
         ASSERT: if (cnt_q == HOLD_END) begin
            state_d = RAM_REL;
            cnt_d   = '0;
            ram_d   = 1'b1;
         end
         RAM_REL: if (cnt_q == LEAD_END) begin
            state_d = WAIT_TICK;
            cnt_d   = '0;
         end
         WAIT_TICK: if (cpu_tick || cnt_q == TICK_END) begin
            state_d = RUN;
            cnt_d   = '0;
            cpu_d   = 1'b1;
            rdy_d   = 1'b1;
            tto_d   = !cpu_tick;
         end
         default: cnt_d = run_cnt;
      endcase
      // A trigger overrides everything, including a coincident tick.
      if (trig) begin
         state_d = ASSERT;
         cnt_d   = '0;
         ram_d   = 1'b0;
         cpu_d   = 1'b0;
         rdy_d   = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         ram_q   <= 1'b0;
         cpu_q   <= 1'b0;
         rdy_q   <= 1'b0;
         tto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ram_q   <= ram_d;
         cpu_q   <= cpu_d;
         rdy_q   <= rdy_d;
         tto_q   <= tto_d;
      end
   end
   assign rst_ram_n    = ram_q;
   assign rst_cpu_n    = cpu_q;
   assign ready        = rdy_q;
   assign tick_timeout = tto_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, hand sequences and random stimulus against an age-based reference model.
module tb_reset_sequencer;
   localparam int HOLD = 16;
   localparam int LEAD = 8;
   localparam int TT   = 32;
   localparam int WDT  = 64;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cpu_tick = 1'b0, soft_rst_req = 1'b0, wdt_kick = 1'b0;
   logic rst_ram_n, rst_cpu_n, ready, tick_timeout, wdt_fired;
   int nvec = 0, nfail = 0;
   int m_sync = 0, m_age = 0, m_since = 0;
   bit m_ram = 0, m_cpu = 0, m_rdy = 0, m_tto = 0, m_wdf = 0;
   typedef struct {int n; bit t; bit s; logic [3:0] e;} vec_t;
   vec_t tbl[$];

   reset_sequencer #(.HOLD_CYCLES(HOLD), .RAM_LEAD(LEAD), .TICK_TIMEOUT(TT), .WDT_CYCLES(WDT)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_tick(cpu_tick), .soft_rst_req(soft_rst_req), .wdt_kick(wdt_kick),
      .rst_ram_n(rst_ram_n), .rst_cpu_n(rst_cpu_n), .ready(ready), .tick_timeout(tick_timeout),
      .wdt_fired(wdt_fired));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // age = active edges since the sequence (re)started; thresholds follow directly from the parameters
   task automatic model_edge(input bit t, input bit s, input bit k);
      bit fire = 0;
      if (m_sync < 2) begin
         m_sync++;
         return;
      end
`ifdef RST_SEQ_WDT_EN
      if (m_cpu) begin
         if (k) m_since = 0;
         else if (m_since == WDT - 1) fire = 1;
         else m_since++;
      end
      if (fire) m_wdf = 1;
      else if (s) m_wdf = 0;
`endif
      if (s || fire) begin
         m_age = 0; m_ram = 0; m_cpu = 0; m_rdy = 0;
         return;
      end
      m_age++;
      if (m_age >= HOLD) m_ram = 1;
      if (!m_cpu && m_age > HOLD + LEAD && (t || m_age == HOLD + LEAD + TT)) begin
         m_cpu = 1; m_rdy = 1; m_tto = !t; m_since = 0;
      end
   endtask

   task automatic step(input bit t, input bit s, input bit k);
      cpu_tick = t; soft_rst_req = s; wdt_kick = k;
      @(posedge clk);
      model_edge(t, s, k);
      #1;
      chk("model", {rst_ram_n, rst_cpu_n, ready, tick_timeout, wdt_fired}, {m_ram, m_cpu, m_rdy, m_tto, m_wdf});
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 chk("async", {rst_ram_n, rst_cpu_n, ready, tick_timeout, wdt_fired}, 0);
      m_sync = 0; m_age = 0; m_ram = 0; m_cpu = 0; m_rdy = 0; m_tto = 0; m_wdf = 0; m_since = 0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic add(input int n, input bit t, input bit s, input logic [3:0] e);
      vec_t v;
      v.n = n; v.t = t; v.s = s; v.e = e;
      tbl.push_back(v);
   endtask

   initial begin
      int ram_at, cpu_at, i;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset", {rst_ram_n, rst_cpu_n, ready, tick_timeout, wdt_fired}, 0);
      // expected {ram, cpu, ready, tick_timeout} after applying each row for n edges
      add(2, 0, 0, 4'b0000);  add(15, 0, 0, 4'b0000); add(1, 0, 0, 4'b1000); add(8, 0, 0, 4'b1000);
      add(31, 0, 0, 4'b1000); add(1, 0, 0, 4'b1111);  add(1, 0, 1, 4'b0001); add(15, 0, 0, 4'b0001);
      add(1, 0, 0, 4'b1001);  add(8, 0, 0, 4'b1001);  add(1, 1, 0, 4'b1110); add(1, 1, 1, 4'b0000);
      add(3, 1, 0, 4'b0000);  add(21, 0, 0, 4'b1000); add(1, 1, 1, 4'b0000); add(24, 0, 0, 4'b1000);
      add(1, 1, 0, 4'b1110);
      @(negedge clk) rst_n = 1'b1;
      foreach (tbl[r]) begin
         repeat (tbl[r].n) step(tbl[r].t, tbl[r].s, 1'b0);
         chk($sformatf("tbl%0d", r), {rst_ram_n, rst_cpu_n, ready, tick_timeout}, tbl[r].e);
      end
      // tick every 10 edges: RAM at edge 18, CPU on the first tick at or after edge 27
      async_reset();
      ram_at = 0; cpu_at = 0; i = 0;
      while (cpu_at == 0 && i < 200) begin
         i++;
         step(i % 10 == 0, 1'b0, 1'b0);
         if (rst_ram_n && ram_at == 0) ram_at = i;
         if (rst_cpu_n) cpu_at = i;
      end
      chk("ram_edge", ram_at, 18);
      chk("cpu_edge", cpu_at, 30);
      chk("tick_tto", tick_timeout, 0);
      // reset mid RAM_REL, then minimum latency with a constant tick
      async_reset();
      repeat (20) step(1'b0, 1'b0, 1'b0);
      chk("mid_ram", rst_ram_n, 1);
      async_reset();
      repeat (26) step(1'b1, 1'b0, 1'b0);
      chk("pre_min", rst_cpu_n, 0);
      step(1'b1, 1'b0, 1'b0);
      chk("min_lat", {rst_cpu_n, ready}, 2'b11);
`ifdef RST_SEQ_WDT_EN
      repeat (63) step(1'b0, 1'b0, 1'b0);
      chk("wdt_pre", {wdt_fired, ready}, 2'b01);
      step(1'b0, 1'b0, 1'b0);
      chk("wdt_fire", {wdt_fired, ready}, 2'b10);
`endif
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 1499) == 0) async_reset();
         step($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
